// File: rtl/fm_sb_rd_arb_pkg.sv
// Shared fast-monitoring spy-buffer definitions: bus widths, tap count,
// tap record struct, arbiter state encoding and an index-width helper.
package fm_sb_pkg;

  localparam int unsigned axi_dw     = 32;
  localparam int unsigned mon_dw_max = 256;
  localparam int unsigned sf_sb_n    = 3;

  // One monitor tap as seen by the wrapper that flattens taps onto src_data.
  typedef struct packed {
    logic [mon_dw_max-1:0] fm_data;
    logic                  fm_vld;
  } fm_rt;

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } fm_arb_state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fm_sb_rd_arb_if.sv
// Tap-side and spy-buffer-side handshake bundle of the spy-buffer read arbiter.
// master: the arbiter; slave: the taps plus the spy-buffer write side.
interface fm_sb_rd_arb_if
  import fm_sb_pkg::*;
#(
  parameter int unsigned SB_N   = sf_sb_n,
  parameter int unsigned MON_DW = mon_dw_max,
  parameter int unsigned AXI_DW = axi_dw
);

  localparam int unsigned SRC_W = idx_w(SB_N);

  logic [SB_N*MON_DW-1:0] src_data;
  logic [SB_N-1:0]        src_vld;
  logic [SB_N-1:0]        src_rdy;
  logic [AXI_DW-1:0]      out_data;
  logic                   out_vld;
  logic                   out_rdy;
  logic                   out_last;
  logic [SRC_W-1:0]       out_src;

  modport master (
    input  src_data, src_vld, out_rdy,
    output src_rdy, out_data, out_vld, out_last, out_src
  );

  modport slave (
    output src_data, src_vld, out_rdy,
    input  src_rdy, out_data, out_vld, out_last, out_src
  );

endinterface

// File: rtl/fm_sb_rd_arb_pick.sv
// Combinational round-robin picker: first set request after last_grant,
// wrapping modulo N. Shared with the playback scheduler.
module fm_rr_pick #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] grant,
  output logic         any
);

  // Scan N positions starting one past the previous winner; first hit wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    any   = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (int'(last_grant) + i) % N;
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = W'(idx);
      end
    end
  end

endmodule

// File: rtl/fm_sb_rd_arb.sv
// Round-robin arbiter/serializer: grants one fm tap, latches its MON_DW word
// and emits it LSB-first as AXI_DW beats tagged with the source tap index.
// Optional macro FM_SB_RD_ARB_STATS_EN adds per-tap saturating grant counters
// (grant_cnt) with a synchronous clear (stats_clr).
module fm_sb_rd_arb
  import fm_sb_pkg::*;
#(
  parameter int unsigned SB_N   = sf_sb_n,
  parameter int unsigned MON_DW = mon_dw_max,
  parameter int unsigned AXI_DW = axi_dw
) (
  input  logic                 spy_clock,
  input  logic                 rst_n,
  fm_sb_rd_arb_if.master       bus,
  input  logic                 arb_en,
  input  logic                 freeze,
  output logic                 busy
`ifdef FM_SB_RD_ARB_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [SB_N*32-1:0]   grant_cnt
`endif
);

  localparam int unsigned BEATS = MON_DW / AXI_DW;
  localparam int unsigned BW    = idx_w(BEATS);
  localparam int unsigned SRC_W = idx_w(SB_N);

  fm_arb_state_t                  state_q, state_d;
  logic [BW-1:0]                  beat_q;
  logic [BEATS-1:0][AXI_DW-1:0]   shreg_q;
  logic [SRC_W-1:0]               src_q;
  logic [SRC_W-1:0]               last_grant_q;
  logic [SRC_W-1:0]               pick_idx;
  logic                           pick_any;
  logic                           grant_en;
  logic                           last_beat;
  logic [MON_DW-1:0]              pick_word;

  fm_rr_pick #(
    .N (SB_N),
    .W (SRC_W)
  ) u_pick (
    .req        (bus.src_vld),
    .last_grant (last_grant_q),
    .grant      (pick_idx),
    .any        (pick_any)
  );

  // Select the winning tap's word for latching.
  always_comb begin
    pick_word = '0;
    for (int unsigned i = 0; i < SB_N; i++) begin
      if (pick_idx == SRC_W'(i)) begin
        pick_word = bus.src_data[i*MON_DW +: MON_DW];
      end
    end
  end

  // Next state and the one-hot accept pulse; grants only from IDLE.
  always_comb begin
    state_d     = state_q;
    grant_en    = 1'b0;
    bus.src_rdy = '0;
    last_beat   = (beat_q == BW'(BEATS - 1));
    case (state_q)
      IDLE: begin
        if (arb_en && !freeze && pick_any) begin
          grant_en = 1'b1;
          state_d  = SERIAL;
          for (int unsigned i = 0; i < SB_N; i++) begin
            bus.src_rdy[i] = (pick_idx == SRC_W'(i));
          end
        end
      end
      SERIAL: begin
        if (bus.out_rdy && last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat outputs come straight from registers, so they hold under backpressure.
  always_comb begin
    busy         = (state_q == SERIAL);
    bus.out_vld  = (state_q == SERIAL);
    bus.out_data = (state_q == SERIAL) ? shreg_q[beat_q] : '0;
    bus.out_last = (state_q == SERIAL) && last_beat;
    bus.out_src  = src_q;
  end

  // State, word latch, beat counter and round-robin history.
  always_ff @(posedge spy_clock) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      shreg_q      <= '0;
      src_q        <= '0;
      last_grant_q <= SRC_W'(SB_N - 1);
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        shreg_q      <= pick_word;
        src_q        <= pick_idx;
        last_grant_q <= pick_idx;
        beat_q       <= '0;
      end else if (state_q == SERIAL && bus.out_rdy) begin
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
      end
    end
  end

`ifdef FM_SB_RD_ARB_STATS_EN
  logic [SB_N-1:0][31:0] cnt_q;

  // Per-tap saturating grant counters; clear beats a same-cycle grant.
  always_ff @(posedge spy_clock) begin
    if (!rst_n || stats_clr) begin
      cnt_q <= '0;
    end else if (grant_en) begin
      for (int unsigned i = 0; i < SB_N; i++) begin
        if (pick_idx == SRC_W'(i) && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fm_sb_rd_arb.sv
// Directed self-checking bench for fm_sb_rd_arb (3 taps, 256-bit words, 32-bit beats).
module tb_fm_sb_rd_arb;
  import fm_sb_pkg::*;

  logic spy_clock;
  logic rst_n;
  logic arb_en;
  logic freeze;
  logic busy;
`ifdef FM_SB_RD_ARB_STATS_EN
  logic        stats_clr;
  logic [95:0] grant_cnt;
`endif

  int unsigned tests;
  int unsigned fails;

  fm_sb_rd_arb_if #(.SB_N(3), .MON_DW(256), .AXI_DW(32)) bus ();

  fm_sb_rd_arb #(.SB_N(3), .MON_DW(256), .AXI_DW(32)) dut (
    .spy_clock (spy_clock),
    .rst_n     (rst_n),
    .bus       (bus),
    .arb_en    (arb_en),
    .freeze    (freeze),
    .busy      (busy)
`ifdef FM_SB_RD_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  initial begin
    spy_clock = 1'b0;
    forever #5 spy_clock = ~spy_clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge spy_clock);
    #1;
  endtask

  function automatic logic [255:0] mk(input int unsigned base);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = base + k + 1;
    return w;
  endfunction

  // Expect a full 8-beat word with out_rdy held high; call one cycle after the grant edge.
  task automatic word(input int unsigned src, input int unsigned base, input string tag);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk({tag, "_vld"},  64'(bus.out_vld), 64'd1);
      chk({tag, "_data"}, 64'(bus.out_data), 64'(base + k + 1));
      chk({tag, "_last"}, 64'(bus.out_last), 64'(k == 7));
      chk({tag, "_src"},  64'(bus.out_src), 64'(src));
      chk({tag, "_rdy0"}, 64'(bus.src_rdy), 64'd0);
      cyc();
    end
  endtask

  initial begin
    int unsigned acc;
    int unsigned n;
    tests        = 0;
    fails        = 0;
    rst_n        = 1'b0;
    arb_en       = 1'b0;
    freeze       = 1'b0;
    bus.src_vld  = '0;
    bus.out_rdy  = 1'b0;
    bus.src_data = {mk(32'h300), mk(32'h200), mk(32'h000)};
`ifdef FM_SB_RD_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    cyc();
    cyc();
    #1;
    chk("rst_vld",  64'(bus.out_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_src",  64'(bus.out_src), 64'd0);
    chk("rst_rdy",  64'(bus.src_rdy), 64'd0);

    // Single tap: one-cycle accept, beats 1..8, then an idle bubble.
    rst_n       = 1'b1;
    arb_en      = 1'b1;
    bus.out_rdy = 1'b1;
    cyc();
    bus.src_vld = 3'b001;
    #1;
    chk("t1_grant", 64'(bus.src_rdy), 64'd1);
    chk("t1_idle_vld", 64'(bus.out_vld), 64'd0);
    cyc();
    bus.src_vld = '0;
    word(0, 32'h000, "t1");
    #1;
    chk("t1_bubble_vld",  64'(bus.out_vld), 64'd0);
    chk("t1_bubble_busy", 64'(busy), 64'd0);
    chk("t1_bubble_rdy",  64'(bus.src_rdy), 64'd0);

    // Fresh history, then all three taps requesting: order 0,1,2,0,1,2 at 9 cycles each.
    bus.src_data = {mk(32'h300), mk(32'h200), mk(32'h100)};
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.src_vld = 3'b111;
    for (int w = 0; w < 6; w++) begin
      #1;
      chk("rr_grant", 64'(bus.src_rdy), 64'(1 << (w % 3)));
      cyc();
      if (w == 5) bus.src_vld = '0;
      word(w % 3, 32'h100 * ((w % 3) + 1), "rr");
    end
    #1;
    chk("rr_end_vld", 64'(bus.out_vld), 64'd0);

    // Backpressure pattern 1,0,0,1,0,0,... on tap0's word.
    bus.src_vld = 3'b001;
    #1;
    chk("bp_grant", 64'(bus.src_rdy), 64'd1);
    cyc();
    bus.src_vld = '0;
    acc = 0;
    n   = 0;
    while (acc < 8 && n < 40) begin
      bus.out_rdy = (n % 3 == 0);
      #1;
      chk("bp_vld",  64'(bus.out_vld), 64'd1);
      chk("bp_data", 64'(bus.out_data), 64'(32'h100 + acc + 1));
      chk("bp_last", 64'(bus.out_last), 64'(acc == 7));
      chk("bp_rdy0", 64'(bus.src_rdy), 64'd0);
      if (bus.out_rdy) acc++;
      n++;
      cyc();
    end
    chk("bp_count", 64'(acc), 64'd8);
    bus.out_rdy = 1'b1;
    #1;
    chk("bp_done_vld", 64'(bus.out_vld), 64'd0);
    cyc();

    // Freeze on beat 3 of tap1's word while tap2 waits.
    bus.src_vld = 3'b110;
    #1;
    chk("fz_grant1", 64'(bus.src_rdy), 64'd2);
    cyc();
    bus.src_vld = 3'b100;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) freeze = 1'b1;
      #1;
      chk("fz_vld",  64'(bus.out_vld), 64'd1);
      chk("fz_data", 64'(bus.out_data), 64'(32'h200 + k + 1));
      chk("fz_rdy0", 64'(bus.src_rdy), 64'd0);
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fz_hold_rdy", 64'(bus.src_rdy), 64'd0);
      chk("fz_hold_vld", 64'(bus.out_vld), 64'd0);
      cyc();
    end
    freeze = 1'b0;
    #1;
    chk("fz_grant2", 64'(bus.src_rdy), 64'd4);
    cyc();
    bus.src_vld = '0;
    word(2, 32'h300, "fz2");

    // arb_en low blocks a grant.
    arb_en = 1'b0;
    bus.src_vld = 3'b010;
    #1;
    chk("en_block_rdy", 64'(bus.src_rdy), 64'd0);
    cyc();
    #1;
    chk("en_block_vld", 64'(bus.out_vld), 64'd0);
    arb_en = 1'b1;
    #1;
    chk("en_grant", 64'(bus.src_rdy), 64'd2);
    cyc();
    bus.src_vld = '0;

    // Reset on beat 5 of tap1's word; afterwards tap0 wins despite history.
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rs_data", 64'(bus.out_data), 64'(32'h200 + k + 1));
      if (k == 4) rst_n = 1'b0;
      cyc();
    end
    #1;
    chk("rs_vld",  64'(bus.out_vld), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    bus.src_vld = 3'b111;
    #1;
    chk("rs_grant", 64'(bus.src_rdy), 64'd1);
    cyc();
    bus.src_vld = '0;
    word(0, 32'h100, "rs");
    #1;
    chk("rs_end_vld", 64'(bus.out_vld), 64'd0);

`ifdef FM_SB_RD_ARB_STATS_EN
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    for (int r = 0; r < 5; r++) begin
      bus.src_vld = 3'b100;
      cyc();
      bus.src_vld = '0;
      word(2, 32'h300, "st");
    end
    #1;
    chk("st_cnt2", 64'(grant_cnt[95:64]), 64'd5);
    chk("st_cnt0", 64'(grant_cnt[31:0]), 64'd0);
    bus.src_vld = 3'b100;
    stats_clr   = 1'b1;
    cyc();
    stats_clr   = 1'b0;
    bus.src_vld = '0;
    #1;
    chk("st_clr", 64'(grant_cnt[95:64]), 64'd0);
    word(2, 32'h300, "st_clr");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
